// File: rtl/axist_link_test_seq_pkg.sv
// Shared types for the AXI-ST link test sequencer: state encoding, error codes
// and checker result encodings.
package axist_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_TX = 3'd1,
    ST_RELEASE = 3'd2,
    ST_WAIT_RX = 3'd3,
    ST_RUN     = 3'd4,
    ST_DRAIN   = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } seq_state_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_CFG       = 3'd1,
    ERR_LINK_TO   = 3'd2,
    ERR_ALIGN     = 3'd3,
    ERR_BEAT_TO   = 3'd4,
    ERR_CHKR_TO   = 3'd5,
    ERR_CHKR_FAIL = 3'd6,
    ERR_ABORT     = 3'd7
  } err_code_e;

  localparam logic [1:0] CHKR_BUSY = 2'b00;
  localparam logic [1:0] CHKR_PASS = 2'b01;

  function automatic logic chkr_failed(input logic [1:0] res);
    return res[1];
  endfunction

endpackage

// File: rtl/axist_link_test_seq_if.sv
// Pattern generator / checker control bundle between the sequencer (master)
// and the patgen/checker block (slave).
interface axist_link_test_seq_if;
  logic       o_patgen_en;
  logic [1:0] o_patgen_sel;
  logic [8:0] o_patgen_cnt;
  logic       o_cntuspatt_en;
  logic       i_tx_beat;
  logic [1:0] i_chkr_pass;

  modport master (
    output o_patgen_en, o_patgen_sel, o_patgen_cnt, o_cntuspatt_en,
    input  i_tx_beat, i_chkr_pass
  );

  modport slave (
    input  o_patgen_en, o_patgen_sel, o_patgen_cnt, o_cntuspatt_en,
    output i_tx_beat, i_chkr_pass
  );
endinterface

// File: rtl/axist_seq_timer.sv
// Per-state timeout counter: restart begins a fresh interval, expire flags the
// cycle in which the live count equals LIMIT-1.
module axist_seq_timer #(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic expire
);
  localparam int unsigned W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  // restart is raised during the first cycle of a new interval, so the live
  // count reads as zero then and the register already holds the next value.
  assign expire = restart ? (LAST == '0) : (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= (LAST == '0) ? '0 : W'(1);
    end else if (cnt != LAST) begin
      cnt <= cnt + W'(1);
    end
  end
endmodule

// File: rtl/axist_link_test_seq.sv
// Sequences one AXI-ST-over-AIB link test: TX online, AXI-ST reset pulse,
// RX alignment, counted or continuous pattern run, checker verdict.
module axist_link_test_seq
  import axist_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES  = 65535,
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned BEAT_CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic                  i_abort,
  input  logic [1:0]            i_patgen_sel,
  input  logic [8:0]            i_patgen_cnt,
  input  logic                  i_cntuspatt_en,
  input  logic                  i_ldr_tx_online,
  input  logic                  i_fllr_tx_online,
  input  logic                  i_ldr_rx_online,
  input  logic                  i_fllr_rx_online,
  input  logic                  i_align_err,
  axist_link_test_seq_if.master pg,
  output logic                  o_axist_rstn,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [2:0]            o_err_code,
  output logic [2:0]            o_state,
  output logic [BEAT_CNT_W-1:0] o_beat_cnt
);
  localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

  seq_state_e            state;
  logic [HOLD_W-1:0]     hold_cnt;
  logic                  tmr_restart;
  logic                  tmr_expire;
  logic                  busy_st;
  logic                  fail_now;
  err_code_e             fail_code;
  logic [BEAT_CNT_W-1:0] beat_nxt;
  logic                  cnt_hit;

  assign o_state = state;

  axist_seq_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (tmr_restart),
    .expire  (tmr_expire)
  );

  // Failure decode: abort outranks every error, errors outrank advances.
  always_comb begin
    busy_st   = state inside {ST_WAIT_TX, ST_RELEASE, ST_WAIT_RX, ST_RUN, ST_DRAIN};
    beat_nxt  = (&o_beat_cnt) ? o_beat_cnt : o_beat_cnt + BEAT_CNT_W'(1);
    cnt_hit   = pg.i_tx_beat && !pg.o_cntuspatt_en &&
                (beat_nxt == BEAT_CNT_W'(pg.o_patgen_cnt));
    fail_now  = 1'b0;
    fail_code = ERR_NONE;
    unique case (state)
      ST_WAIT_TX: if (tmr_expire) begin fail_now = 1'b1; fail_code = ERR_LINK_TO; end
      ST_WAIT_RX: begin
        if (i_align_err)     begin fail_now = 1'b1; fail_code = ERR_ALIGN;   end
        else if (tmr_expire) begin fail_now = 1'b1; fail_code = ERR_LINK_TO; end
      end
      ST_RUN: if (tmr_expire && !pg.i_tx_beat) begin fail_now = 1'b1; fail_code = ERR_BEAT_TO; end
      ST_DRAIN: begin
        if (chkr_failed(pg.i_chkr_pass)) begin fail_now = 1'b1; fail_code = ERR_CHKR_FAIL; end
        else if (tmr_expire)             begin fail_now = 1'b1; fail_code = ERR_CHKR_TO;   end
      end
      default: ;
    endcase
    if (busy_st && i_abort) begin
      fail_now  = 1'b1;
      fail_code = ERR_ABORT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      hold_cnt          <= '0;
      tmr_restart       <= 1'b0;
      o_axist_rstn      <= 1'b1;
      pg.o_patgen_en    <= 1'b0;
      pg.o_patgen_sel   <= '0;
      pg.o_patgen_cnt   <= '0;
      pg.o_cntuspatt_en <= 1'b0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_pass            <= 1'b0;
      o_err_code        <= ERR_NONE;
      o_beat_cnt        <= '0;
    end else begin
      tmr_restart <= 1'b0;
      if (state == ST_RUN && pg.i_tx_beat) begin
        o_beat_cnt  <= beat_nxt;
        tmr_restart <= 1'b1;
      end
      if (fail_now) begin
        state          <= ST_ERROR;
        o_err_code     <= fail_code;
        o_busy         <= 1'b0;
        pg.o_patgen_en <= 1'b0;
        o_axist_rstn   <= 1'b1;
        tmr_restart    <= 1'b1;
      end else begin
        unique case (state)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (i_start) begin
              pg.o_patgen_sel   <= i_patgen_sel;
              pg.o_patgen_cnt   <= i_patgen_cnt;
              pg.o_cntuspatt_en <= i_cntuspatt_en;
              o_beat_cnt        <= '0;
              o_done            <= 1'b0;
              o_pass            <= 1'b0;
              o_err_code        <= ERR_NONE;
              tmr_restart       <= 1'b1;
              if (i_patgen_cnt == '0 && !i_cntuspatt_en) begin
                state      <= ST_ERROR;
                o_err_code <= ERR_CFG;
              end else begin
                state  <= ST_WAIT_TX;
                o_busy <= 1'b1;
              end
            end
          end
          ST_WAIT_TX: begin
            if (i_ldr_tx_online && i_fllr_tx_online) begin
              state        <= ST_RELEASE;
              o_axist_rstn <= 1'b0;
              hold_cnt     <= '0;
              tmr_restart  <= 1'b1;
            end
          end
          ST_RELEASE: begin
            if (hold_cnt == HOLD_LAST) begin
              state        <= ST_WAIT_RX;
              o_axist_rstn <= 1'b1;
              tmr_restart  <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
          ST_WAIT_RX: begin
            if (i_ldr_rx_online && i_fllr_rx_online) begin
              state          <= ST_RUN;
              pg.o_patgen_en <= 1'b1;
              tmr_restart    <= 1'b1;
            end
          end
          ST_RUN: begin
            if (cnt_hit || (pg.o_cntuspatt_en && i_stop)) begin
              state       <= ST_DRAIN;
              tmr_restart <= 1'b1;
            end
          end
          ST_DRAIN: begin
            if (pg.i_chkr_pass == CHKR_PASS) begin
              state          <= ST_DONE;
              o_done         <= 1'b1;
              o_pass         <= 1'b1;
              o_busy         <= 1'b0;
              pg.o_patgen_en <= 1'b0;
              o_axist_rstn   <= 1'b1;
              tmr_restart    <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_axist_link_test_seq.sv
// Randomized scenario bench for axist_link_test_seq; expectations come from the
// documented sequencing rules (timeouts, hold length, beat totals, error codes).
module tb_axist_link_test_seq;
  localparam int unsigned TO   = 100;
  localparam int unsigned HOLD = 16;

  logic clk = 1'b0;
  logic rst, i_start, i_stop, i_abort, i_cntuspatt_en;
  logic [1:0] i_patgen_sel;
  logic [8:0] i_patgen_cnt;
  logic i_ldr_tx_online, i_fllr_tx_online, i_ldr_rx_online, i_fllr_rx_online, i_align_err;
  logic o_axist_rstn, o_busy, o_done, o_pass;
  logic [2:0] o_err_code, o_state;
  logic [15:0] o_beat_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  axist_link_test_seq_if pg();

  axist_link_test_seq #(.TIMEOUT_CYCLES(TO), .RST_HOLD_CYCLES(HOLD), .BEAT_CNT_W(16)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop), .i_abort(i_abort),
    .i_patgen_sel(i_patgen_sel), .i_patgen_cnt(i_patgen_cnt), .i_cntuspatt_en(i_cntuspatt_en),
    .i_ldr_tx_online(i_ldr_tx_online), .i_fllr_tx_online(i_fllr_tx_online),
    .i_ldr_rx_online(i_ldr_rx_online), .i_fllr_rx_online(i_fllr_rx_online),
    .i_align_err(i_align_err), .pg(pg), .o_axist_rstn(o_axist_rstn), .o_busy(o_busy),
    .o_done(o_done), .o_pass(o_pass), .o_err_code(o_err_code), .o_state(o_state),
    .o_beat_cnt(o_beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    i_start = 0; i_stop = 0; i_abort = 0; i_cntuspatt_en = 0;
    i_patgen_sel = 0; i_patgen_cnt = 0; i_align_err = 0;
    i_ldr_tx_online = 0; i_fllr_tx_online = 0; i_ldr_rx_online = 0; i_fllr_rx_online = 0;
    pg.i_tx_beat = 0; pg.i_chkr_pass = 2'b00;
  endtask

  task automatic links(input logic on);
    i_ldr_tx_online = on; i_fllr_tx_online = on; i_ldr_rx_online = on; i_fllr_rx_online = on;
  endtask

  task automatic start(input logic [1:0] sel, input logic [8:0] cnt, input logic cont);
    i_patgen_sel = sel; i_patgen_cnt = cnt; i_cntuspatt_en = cont; i_start = 1;
    tick();
    i_start = 0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (o_state == s) begin ok = 1; break; end
      tick();
    end
    if (o_state == s) ok = 1;
  endtask

  task automatic beat();
    pg.i_tx_beat = 1;
    tick();
    pg.i_tx_beat = 0;
  endtask

  task automatic test_reset();
    quiet();
    rst = 1; tick(); tick(); rst = 0;
    n_checks++;
    if ({o_axist_rstn, o_state} !== {1'b1, 3'd0}) begin
      n_fail++; $display("FAIL reset_state: got rstn=%b state=%0d required rstn=1 state=0", o_axist_rstn, o_state);
    end
    n_checks++;
    if ({pg.o_patgen_en, pg.o_patgen_sel, pg.o_patgen_cnt, pg.o_cntuspatt_en, o_busy, o_done, o_pass, o_err_code, o_beat_cnt} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got en=%b sel=%0d cnt=%0d cont=%b busy=%b done=%b pass=%b err=%0d beats=%0d required all 0",
        pg.o_patgen_en, pg.o_patgen_sel, pg.o_patgen_cnt, pg.o_cntuspatt_en, o_busy, o_done, o_pass, o_err_code, o_beat_cnt);
    end
  endtask

  task automatic run_pass_once();
    logic [8:0] cnt = 9'($urandom_range(1, 40));
    logic [1:0] sel = 2'($urandom_range(0, 3));
    int  low = 0;
    int  sent = 0;
    bit  ok = 0;
    bit  en_ok = 1;
    quiet();
    start(sel, cnt, 1'b0);
    n_checks++;
    if ({o_state, o_busy, o_err_code, o_done, o_pass} !== {3'd1, 1'b1, 3'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL start_busy: got state=%0d busy=%b err=%0d done=%b pass=%b required 1,1,0,0,0", o_state, o_busy, o_err_code, o_done, o_pass);
    end
    n_checks++;
    if ({pg.o_patgen_sel, pg.o_patgen_cnt, pg.o_cntuspatt_en, o_beat_cnt} !== {sel, cnt, 1'b0, 16'd0}) begin
      n_fail++; $display("FAIL start_latch: got sel=%0d cnt=%0d cont=%b beats=%0d required %0d %0d 0 0", pg.o_patgen_sel, pg.o_patgen_cnt, pg.o_cntuspatt_en, o_beat_cnt, sel, cnt);
    end
    repeat (3) tick();
    i_ldr_tx_online = 1; i_fllr_tx_online = 1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!o_axist_rstn) low++;
      if (o_state == 3'd3) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok || low != HOLD) begin
      n_fail++; $display("FAIL rstn_low: got reached=%0d low_cycles=%0d required reached=1 low_cycles=%0d", ok, low, HOLD);
    end
    repeat (20) tick();
    n_checks++;
    if (o_state !== 3'd3) begin
      n_fail++; $display("FAIL wait_rx_hold: got state=%0d required 3", o_state);
    end
    i_ldr_rx_online = 1; i_fllr_rx_online = 1;
    tick();
    n_checks++;
    if ({o_state, pg.o_patgen_en} !== {3'd4, 1'b1}) begin
      n_fail++; $display("FAIL run_entry: got state=%0d en=%b required 4 1", o_state, pg.o_patgen_en);
    end
    for (int b = 0; b < int'(cnt); b++) begin
      repeat ($urandom_range(0, 3)) begin
        i_stop = 1'($urandom);
        tick();
        en_ok &= (pg.o_patgen_en === 1'b1);
      end
      i_stop = 0;
      if (b == int'(cnt) - 1) begin
        n_checks++;
        if ({o_state, o_beat_cnt} !== {3'd4, 16'(sent)}) begin
          n_fail++; $display("FAIL run_before_last: got state=%0d beats=%0d required 4 %0d", o_state, o_beat_cnt, sent);
        end
      end
      beat();
      sent++;
      en_ok &= (pg.o_patgen_en === 1'b1);
    end
    n_checks++;
    if ({o_state, o_beat_cnt} !== {3'd5, 16'(sent)}) begin
      n_fail++; $display("FAIL drain_entry: got state=%0d beats=%0d required 5 %0d", o_state, o_beat_cnt, sent);
    end
    repeat ($urandom_range(0, 10)) begin
      tick();
      en_ok &= (pg.o_patgen_en === 1'b1) && (o_state === 3'd5);
    end
    pg.i_chkr_pass = 2'b01;
    tick();
    pg.i_chkr_pass = 2'b00;
    n_checks++;
    if (!en_ok) begin
      n_fail++; $display("FAIL patgen_en_span: got en dropped=1 required en held through RUN and DRAIN");
    end
    n_checks++;
    if ({o_state, o_done, o_pass, o_err_code, o_busy, pg.o_patgen_en, o_axist_rstn} !== {3'd6, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL done_report: got state=%0d done=%b pass=%b err=%0d busy=%b en=%b rstn=%b required 6 1 1 0 0 0 1",
        o_state, o_done, o_pass, o_err_code, o_busy, pg.o_patgen_en, o_axist_rstn);
    end
    n_checks++;
    if ({o_beat_cnt, pg.o_patgen_sel, pg.o_patgen_cnt} !== {16'(sent), sel, cnt}) begin
      n_fail++; $display("FAIL done_hold: got beats=%0d sel=%0d cnt=%0d required %0d %0d %0d", o_beat_cnt, pg.o_patgen_sel, pg.o_patgen_cnt, sent, sel, cnt);
    end
  endtask

  task automatic test_pass_path();
    repeat (3) run_pass_once();
  endtask

  task automatic test_cfg_err();
    int low = 0;
    quiet();
    start(2'($urandom_range(0, 3)), 9'd0, 1'b0);
    if (!o_axist_rstn) low++;
    n_checks++;
    if ({o_state, o_err_code, o_busy, o_done} !== {3'd7, 3'd1, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL cfg_err: got state=%0d err=%0d busy=%b done=%b required 7 1 0 0", o_state, o_err_code, o_busy, o_done);
    end
    repeat (5) begin tick(); if (!o_axist_rstn) low++; end
    n_checks++;
    if (low != 0 || o_state !== 3'd7) begin
      n_fail++; $display("FAIL cfg_rstn: got low_cycles=%0d state=%0d required 0 7", low, o_state);
    end
  endtask

  task automatic test_link_timeout();
    int k;
    quiet();
    start(2'd1, 9'd5, 1'b0);
    for (k = 1; k <= int'(TO) + 10; k++) begin
      tick();
      if (o_state != 3'd1) break;
    end
    n_checks++;
    if (k != int'(TO) || o_err_code !== 3'd2 || o_state !== 3'd7) begin
      n_fail++; $display("FAIL link_timeout: got cycles=%0d err=%0d state=%0d required %0d 2 7", k, o_err_code, o_state, TO);
    end
  endtask

  task automatic test_align_err();
    bit ok;
    quiet();
    i_ldr_tx_online = 1; i_fllr_tx_online = 1;
    start(2'($urandom_range(0, 3)), 9'($urandom_range(1, 511)), 1'b0);
    wait_state(3'd3, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL align_reach: got state=%0d required 3", o_state);
    end
    i_align_err = 1; i_ldr_rx_online = 1; i_fllr_rx_online = 1;
    tick();
    quiet();
    n_checks++;
    if ({o_state, o_err_code, pg.o_patgen_en, o_axist_rstn} !== {3'd7, 3'd3, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL align_err: got state=%0d err=%0d en=%b rstn=%b required 7 3 0 1", o_state, o_err_code, pg.o_patgen_en, o_axist_rstn);
    end
  endtask

  task automatic test_beat_timeout();
    bit ok;
    int k;
    quiet();
    links(1'b1);
    start(2'd2, 9'($urandom_range(10, 60)), 1'b0);
    wait_state(3'd4, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL beat_to_reach: got state=%0d required 4", o_state);
    end
    repeat (3) begin
      repeat ($urandom_range(0, 3)) tick();
      beat();
    end
    for (k = 1; k <= int'(TO) + 10; k++) begin
      tick();
      if (o_state != 3'd4) break;
    end
    n_checks++;
    if (k != int'(TO)) begin
      n_fail++; $display("FAIL beat_to_cycles: got %0d required %0d", k, TO);
    end
    n_checks++;
    if ({o_state, o_err_code, o_beat_cnt, pg.o_patgen_en} !== {3'd7, 3'd4, 16'd3, 1'b0}) begin
      n_fail++; $display("FAIL beat_to_err: got state=%0d err=%0d beats=%0d en=%b required 7 4 3 0", o_state, o_err_code, o_beat_cnt, pg.o_patgen_en);
    end
  endtask

  task automatic test_continuous_fail();
    bit ok;
    int sent = 0;
    int gap = 0;
    quiet();
    links(1'b1);
    start(2'd3, 9'd0, 1'b1);
    wait_state(3'd4, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL cont_reach: got state=%0d required 4", o_state);
    end
    while (sent < 300) begin
      pg.i_tx_beat = ($urandom_range(0, 3) != 0) || (gap >= 4);
      tick();
      if (pg.i_tx_beat) begin sent++; gap = 0; end else gap++;
    end
    pg.i_tx_beat = 0;
    n_checks++;
    if ({o_state, o_beat_cnt} !== {3'd4, 16'd300}) begin
      n_fail++; $display("FAIL cont_run: got state=%0d beats=%0d required 4 300", o_state, o_beat_cnt);
    end
    i_stop = 1; tick(); i_stop = 0;
    n_checks++;
    if ({o_state, pg.o_patgen_en} !== {3'd5, 1'b1}) begin
      n_fail++; $display("FAIL cont_stop: got state=%0d en=%b required 5 1", o_state, pg.o_patgen_en);
    end
    pg.i_chkr_pass = {1'b1, 1'($urandom)};
    tick();
    pg.i_chkr_pass = 2'b00;
    n_checks++;
    if ({o_state, o_err_code, o_pass, o_done, pg.o_patgen_en} !== {3'd7, 3'd6, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL cont_chkr_fail: got state=%0d err=%0d pass=%b done=%b en=%b required 7 6 0 0 0", o_state, o_err_code, o_pass, o_done, pg.o_patgen_en);
    end
  endtask

  task automatic test_abort();
    bit ok;
    quiet();
    links(1'b1);
    start(2'd1, 9'd20, 1'b0);
    wait_state(3'd4, 40, ok);
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL abort_reach: got state=%0d required 4", o_state);
    end
    beat(); tick(); beat();
    i_abort = 1;
    tick();
    n_checks++;
    if ({o_state, o_err_code, o_busy, pg.o_patgen_en, o_axist_rstn} !== {3'd7, 3'd7, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL abort_run: got state=%0d err=%0d busy=%b en=%b rstn=%b required 7 7 0 0 1", o_state, o_err_code, o_busy, pg.o_patgen_en, o_axist_rstn);
    end
    tick();
    i_abort = 0;
    n_checks++;
    if ({o_state, o_err_code, o_beat_cnt} !== {3'd7, 3'd7, 16'd2}) begin
      n_fail++; $display("FAIL abort_hold: got state=%0d err=%0d beats=%0d required 7 7 2", o_state, o_err_code, o_beat_cnt);
    end
  endtask

  task automatic test_restart_after_error();
    run_pass_once();
  endtask

  task automatic test_reset_mid();
    bit ok;
    quiet();
    i_ldr_tx_online = 1; i_fllr_tx_online = 1;
    start(2'd2, 9'd10, 1'b1);
    wait_state(3'd2, 10, ok);
    n_checks++;
    if (!ok || o_axist_rstn !== 1'b0) begin
      n_fail++; $display("FAIL release_reach: got state=%0d rstn=%b required 2 0", o_state, o_axist_rstn);
    end
    rst = 1; tick(); rst = 0;
    n_checks++;
    if ({o_axist_rstn, o_state, o_busy, o_err_code, pg.o_patgen_en, pg.o_patgen_sel, pg.o_patgen_cnt, pg.o_cntuspatt_en} !== {1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 2'd0, 9'd0, 1'b0}) begin
      n_fail++; $display("FAIL reset_mid: got rstn=%b state=%0d busy=%b err=%0d en=%b sel=%0d cnt=%0d cont=%b required 1 0 0 0 0 0 0 0",
        o_axist_rstn, o_state, o_busy, o_err_code, pg.o_patgen_en, pg.o_patgen_sel, pg.o_patgen_cnt, pg.o_cntuspatt_en);
    end
    i_abort = 1; tick(); i_abort = 0;
    n_checks++;
    if ({o_state, o_err_code} !== {3'd0, 3'd0}) begin
      n_fail++; $display("FAIL abort_idle: got state=%0d err=%0d required 0 0", o_state, o_err_code);
    end
  endtask

  initial begin
    rst = 1;
    quiet();
    test_reset();
    test_pass_path();
    test_cfg_err();
    test_link_timeout();
    test_align_err();
    test_beat_timeout();
    test_continuous_fail();
    test_abort();
    test_restart_after_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog");
  end
endmodule
